// File: rtl/flag_scheduler_if.sv
// Control/status bundle between the flag scheduler and its environment.
// The master side drives frame timing and buttons; the slave side reports the selection.
interface flag_scheduler_if #(
    parameter int SEL_W = 4
);
    logic             frame_start;
    logic             auto_en;
    logic             btn_next;
    logic             btn_prev;
    logic             btn_pause;
    logic [SEL_W-1:0] flag_sel;
    logic [SEL_W-1:0] target;
    logic             paused;
    logic             change_pending;

    modport master (
        output frame_start, auto_en, btn_next, btn_prev, btn_pause,
        input  flag_sel, target, paused, change_pending
    );

    modport slave (
        input  frame_start, auto_en, btn_next, btn_prev, btn_pause,
        output flag_sel, target, paused, change_pending
    );
endinterface

// File: rtl/flag_scheduler.sv
// Chooses which flag the pixel path shows: debounced next/prev/pause buttons plus
// frame-counted auto-advance, with the selection committed only on frame_start.
module flag_scheduler #(
    parameter int NUM_FLAGS    = 16,
    parameter int SEL_W        = 4,
    parameter int DWELL_FRAMES = 180,
    parameter int DB_CYCLES    = 65536
) (
    input  logic clk,
    input  logic rst_n,
    flag_scheduler_if.slave bus
);
    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int DW_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL_FRAMES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_FLAGS - 1);

    typedef enum logic {RUN, PAUSED} mode_t;

    function automatic logic [SEL_W-1:0] incWrap(input logic [SEL_W-1:0] v);
        return (v == SEL_LAST) ? '0 : v + SEL_W'(1);
    endfunction

    function automatic logic [SEL_W-1:0] decWrap(input logic [SEL_W-1:0] v);
        return (v == '0) ? SEL_LAST : v - SEL_W'(1);
    endfunction

    // Button bit order throughout: [0]=next, [1]=prev, [2]=pause.
    logic [2:0]      w_btnRaw;
    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [DB_W-1:0] r_dbCnt [3];
    logic [2:0]      r_fired;
    logic [2:0]      w_event;

    mode_t           r_state;
    mode_t           w_stateNext;

    logic [SEL_W-1:0] r_flagSel;
    logic [SEL_W-1:0] r_target;
    logic [DW_W-1:0]  r_dwell;
    logic             r_changePending;

    logic             w_runAuto;
    logic             w_manual;
    logic             w_autoAdv;
    logic [SEL_W-1:0] w_manualTarget;
    logic [SEL_W-1:0] w_targetNext;
    logic [SEL_W-1:0] w_flagSelNext;
    logic [DW_W-1:0]  w_dwellNext;

    assign w_btnRaw = {bus.btn_pause, bus.btn_prev, bus.btn_next};

    // r_fired latches after the event so a held button yields exactly one press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_fired <= '0;
            for (int i = 0; i < 3; i++) begin
                r_dbCnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_btnRaw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                if (!r_sync2[i]) begin
                    r_dbCnt[i] <= '0;
                    r_fired[i] <= 1'b0;
                end else if (r_dbCnt[i] == DB_LAST) begin
                    r_fired[i] <= 1'b1;
                end else begin
                    r_dbCnt[i] <= r_dbCnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_event = '0;
        for (int i = 0; i < 3; i++) begin
            w_event[i] = r_sync2[i] && (r_dbCnt[i] == DB_LAST) && !r_fired[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if (w_event[2]) begin
            w_stateNext = (r_state == RUN) ? PAUSED : RUN;
        end
    end

    always_comb begin
        bus.paused = (r_state == PAUSED);
    end

    // Manual step applies first; the auto-advance then adds +1 unless a next press
    // landed on the same frame_start, which restarts the dwell instead.
    always_comb begin
        w_runAuto = (r_state == RUN) && bus.auto_en;
        w_manual  = w_event[0] || w_event[1];

        w_manualTarget = r_target;
        if (w_event[0] && !w_event[1]) begin
            w_manualTarget = incWrap(r_target);
        end else if (w_event[1] && !w_event[0]) begin
            w_manualTarget = decWrap(r_target);
        end

        w_autoAdv = bus.frame_start && w_runAuto && (r_dwell == DW_LAST) && !w_event[0];

        w_dwellNext = r_dwell;
        if (w_manual) begin
            w_dwellNext = '0;
        end else if (bus.frame_start && w_runAuto) begin
            w_dwellNext = (r_dwell == DW_LAST) ? '0 : r_dwell + DW_W'(1);
        end

        w_targetNext  = w_manualTarget;
        w_flagSelNext = r_flagSel;
        if (bus.frame_start) begin
            w_targetNext  = w_autoAdv ? incWrap(w_manualTarget) : w_manualTarget;
            w_flagSelNext = w_targetNext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flagSel       <= '0;
            r_target        <= '0;
            r_dwell         <= '0;
            r_changePending <= 1'b0;
        end else begin
            r_flagSel       <= w_flagSelNext;
            r_target        <= w_targetNext;
            r_dwell         <= w_dwellNext;
            r_changePending <= (w_targetNext != w_flagSelNext);
        end
    end

    assign bus.flag_sel       = r_flagSel;
    assign bus.target         = r_target;
    assign bus.change_pending = r_changePending;
endmodule

// File: tb/tb_flag_scheduler.sv
// Scoreboard bench for flag_scheduler: stimulus queues hand-computed expectations,
// a negedge monitor pops them and compares against the DUT outputs.
module tb_flag_scheduler;
    localparam int NF = 4;
    localparam int SW = 2;
    localparam int DW = 3;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    flag_scheduler_if #(.SEL_W(SW)) bus();

    flag_scheduler #(
        .NUM_FLAGS(NF),
        .SEL_W(SW),
        .DWELL_FRAMES(DW),
        .DB_CYCLES(DB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    string           nameQ [$];
    logic [2*SW+1:0] expQ  [$];
    int              checks = 0;
    int              fails  = 0;

    task automatic checkOutput(input string nm, input int fs, input int tg, input int p, input int cp);
        nameQ.push_back(nm);
        expQ.push_back({SW'(fs), SW'(tg), 1'(p), 1'(cp)});
    endtask

    task automatic compareField(input string nm, input string field, input int got, input int want);
        checks++;
        if (got != want) begin
            fails++;
            $display("[TB] FAIL %s %s: got %0d required %0d", nm, field, got, want);
        end
    endtask

    // Outputs move only on posedge, so the negedge is a stable sampling point.
    always @(negedge clk) begin
        while (expQ.size() > 0) begin
            string           nm;
            logic [2*SW+1:0] e;
            nm = nameQ.pop_front();
            e  = expQ.pop_front();
            compareField(nm, "flag_sel",       int'(bus.flag_sel),       int'(e[2*SW+1:SW+2]));
            compareField(nm, "target",         int'(bus.target),         int'(e[SW+1:2]));
            compareField(nm, "paused",         int'(bus.paused),         int'(e[1]));
            compareField(nm, "change_pending", int'(bus.change_pending), int'(e[0]));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        tick(1);
        bus.frame_start = 1'b0;
        tick(1);
    endtask

    task automatic press(input logic [2:0] mask, input int len);
        {bus.btn_pause, bus.btn_prev, bus.btn_next} = mask;
        tick(len);
        {bus.btn_pause, bus.btn_prev, bus.btn_next} = 3'b000;
        tick(4);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int autoExp [12];
        autoExp = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

        rst_n           = 1'b0;
        bus.frame_start = 1'b0;
        bus.auto_en     = 1'b0;
        bus.btn_next    = 1'b0;
        bus.btn_prev    = 1'b0;
        bus.btn_pause   = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        checkOutput("reset", 0, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            frame();
            checkOutput("hold", 0, 0, 0, 0);
        end

        bus.auto_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            frame();
            checkOutput($sformatf("auto%0d", i + 1), autoExp[i], autoExp[i], 0, 0);
        end
        bus.auto_en = 1'b0;

        press(3'b001, 3);
        checkOutput("glitch", 0, 0, 0, 0);
        press(3'b001, 20);
        checkOutput("debounce", 0, 1, 0, 1);
        frame();
        checkOutput("commit", 1, 1, 0, 0);

        press(3'b010, 20);
        checkOutput("prev_to0", 1, 0, 0, 1);
        frame();
        checkOutput("commit0", 0, 0, 0, 0);
        press(3'b010, 20);
        checkOutput("prev_wrap", 0, 3, 0, 1);
        frame();
        checkOutput("commit3", 3, 3, 0, 0);
        press(3'b011, 20);
        checkOutput("cancel", 3, 3, 0, 0);
        press(3'b001, 20);
        checkOutput("next_wrap", 3, 0, 0, 1);
        press(3'b001, 20);
        checkOutput("next_twice", 3, 1, 0, 1);
        frame();
        checkOutput("commit_plus2", 1, 1, 0, 0);

        bus.auto_en = 1'b1;
        frame();
        checkOutput("dwell1", 1, 1, 0, 0);
        press(3'b100, 20);
        checkOutput("pause_on", 1, 1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            frame();
            checkOutput("paused_frame", 1, 1, 1, 0);
        end
        press(3'b100, 20);
        checkOutput("pause_off", 1, 1, 0, 0);
        frame();
        checkOutput("resume_dwell2", 1, 1, 0, 0);
        frame();
        checkOutput("resume_adv", 2, 2, 0, 0);

        bus.auto_en = 1'b0;
        press(3'b100, 20);
        checkOutput("pause_on2", 2, 2, 1, 0);
        press(3'b001, 20);
        checkOutput("next_paused", 2, 3, 1, 1);
        frame();
        checkOutput("commit_paused", 3, 3, 1, 0);
        press(3'b100, 20);
        checkOutput("pause_off2", 3, 3, 0, 0);

        bus.auto_en = 1'b1;
        frame();
        checkOutput("coll_dwell1", 3, 3, 0, 0);
        frame();
        checkOutput("coll_dwell2", 3, 3, 0, 0);
        bus.btn_next = 1'b1;
        tick(5);
        bus.frame_start = 1'b1;
        tick(1);
        bus.frame_start = 1'b0;
        tick(1);
        checkOutput("collision", 0, 0, 0, 0);
        tick(13);
        bus.btn_next = 1'b0;
        tick(4);
        checkOutput("coll_single", 0, 0, 0, 0);
        frame();
        checkOutput("coll_cnt_a", 0, 0, 0, 0);
        frame();
        checkOutput("coll_cnt_b", 0, 0, 0, 0);
        frame();
        checkOutput("coll_cnt_adv", 1, 1, 0, 0);

        bus.auto_en = 1'b0;
        press(3'b001, 20);
        checkOutput("pre_reset", 1, 2, 0, 1);
        bus.btn_next = 1'b1;
        tick(3);
        rst_n        = 1'b0;
        bus.btn_next = 1'b0;
        tick(2);
        checkOutput("in_reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        tick(8);
        checkOutput("post_reset", 0, 0, 0, 0);
        frame();
        checkOutput("post_reset_frame", 0, 0, 0, 0);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
